multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU datapath: PC, 16-bit instruction memory, 8×8 register file, 2-bit-control ALU, data memory. It replaces single-cycle combinational control with a Moore FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback, and waits on ready handshakes from both memories. It also counts retired instructions and provides a halt state.

---
 rtl/multicycle_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Purpose: multi-cycle control FSM for the 8-bit CPU datapath (fetch/decode/exec/mem/wb/halt),
//          with a private flag register for branches and a wrapping retired-instruction counter.
// Latency: branch 2, ALU op / STR 4, LDR 5 cycles; each imem/dmem wait cycle adds one.
// Backpressure: imem_req/dmem_req held until the matching ready is sampled; ready with no request is ignored.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   run                start permission, sampled in IDLE and on the retire cycle
//   instr[15:0]        instruction word; opcode/cond latched on the fetch handshake
//   alu_flags[3:0]     {N,Z,C,V}, captured in EXEC of opcodes 000-100
//   imem_ready/_req    instruction fetch handshake
//   dmem_ready/_req    data access handshake (mem_write marks a store)
//   ir_write, pc_write, pc_src, reg_src, alu_ctrl, alu_src, reg_write, mem_to_reg  datapath controls
//   state[2:0]         current FSM state (debug)
//   retired[7:0]       retired-instruction count, wraps 255 -> 0
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  reg_src,
  output logic [1:0]  alu_ctrl,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic [7:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADDI   = 3'b100;
  localparam logic [2:0] OP_LDR    = 3'b101;
  localparam logic [2:0] OP_STR    = 3'b110;
  localparam logic [2:0] OP_B      = 3'b111;
  localparam logic [2:0] COND_HALT = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [2:0]  cond_q, cond_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  retired_q, retired_d;

  logic        taken;
  logic        in_instr;
  state_t      after_retire;

  // Instruction operand bits and the carry flag are consumed by the datapath, not here.
  logic        unused_bits;
  assign unused_bits = ^{instr[9:0], flags_q[1]};

  // Branch condition against the stored flags {N,Z,C,V}; conds 100-110 never taken.
  always_comb begin
    taken = 1'b0;
    case (cond_q)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flags_q[2];
      3'b010:  taken = !flags_q[2];
      3'b011:  taken = flags_q[3] ^ flags_q[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    cond_d       = cond_q;
    flags_d      = flags_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_src      = 2'b00;
    alu_ctrl     = 2'b00;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    after_retire = run ? S_FETCH : S_IDLE;

    // Operand/ALU steering is held steady for the whole life of the latched
    // instruction so the datapath sees no glitches between phases.
    in_instr = (state_q == S_DECODE) || (state_q == S_EXEC) ||
               (state_q == S_MEM)    || (state_q == S_WB);
    if (in_instr) begin
      alu_ctrl   = (opcode_q[2] == 1'b0) ? opcode_q[1:0] : 2'b00;
      alu_src    = (opcode_q == OP_ADDI) || (opcode_q == OP_LDR) || (opcode_q == OP_STR);
      reg_src[0] = (opcode_q == OP_B);
      reg_src[1] = (opcode_q == OP_STR);
      mem_to_reg = (opcode_q == OP_LDR);
    end

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // The IR load must coincide with the accepted word, so this pulse is
        // qualified by the handshake itself.
        if (imem_ready) begin
          ir_write = 1'b1;
          opcode_d = instr[15:13];
          cond_d   = instr[12:10];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode_q == OP_B) begin
          if (cond_q == COND_HALT) begin
            state_d = S_HALT;
          end else begin
            pc_write = 1'b1;
            pc_src   = taken;
            state_d  = after_retire;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode_q <= OP_ADDI) begin
          flags_d = alu_flags;
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_write = (opcode_q == OP_STR);
        if (dmem_ready) begin
          if (opcode_q == OP_STR) begin
            pc_write = 1'b1;
            state_d  = after_retire;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = after_retire;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    retired_d = retired_q + {7'd0, pc_write};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= 3'd0;
      cond_q    <= 3'd0;
      flags_q   <= 4'd0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cond_q    <= cond_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] instr;
  logic [3:0]  alu_flags;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic [1:0]  reg_src;
  logic [1:0]  alu_ctrl;
  logic        alu_src;
  logic        reg_write;
  logic        mem_write;
  logic        mem_to_reg;
  logic [2:0]  state;
  logic [7:0]  retired;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_src    (reg_src),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout: im dm iw pw ps rs[1:0] ac[1:0] as rw mw mr
  logic [12:0] ctl;
  assign ctl = {imem_req, dmem_req, ir_write, pc_write, pc_src, reg_src,
                alu_ctrl, alu_src, reg_write, mem_write, mem_to_reg};

  localparam logic [12:0] C_NONE  = 13'b0_0_0_0_0_00_00_0_0_0_0;
  localparam logic [12:0] C_FETCH = 13'b1_0_1_0_0_00_00_0_0_0_0;

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; instr = 16'h0000; alu_flags = 4'h0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (state !== 3'd0 || ctl !== C_NONE || retired !== 8'd0)
        $display("FAIL reset cyc%0d: state=%0d ctl=%b retired=%0d, expected 0 %b 0",
                 i, state, ctl, retired, C_NONE);
      else n_pass++;
    end
  endtask

  task automatic test_add();
    logic [2:0]  es [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
    logic        r  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [12:0] ec [6] = '{C_NONE, C_FETCH, C_NONE, C_NONE,
                            13'b0_0_0_1_0_00_00_0_1_0_0, C_NONE};
    instr = 16'h0000; imem_ready = 1'b1; dmem_ready = 1'b1; alu_flags = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); run = r[i]; #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL add cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
    n_checks++;
    if (retired !== 8'd1) $display("FAIL add retired: got %0d expected 1", retired);
    else n_pass++;
  endtask

  task automatic test_ldr_wait();
    logic [2:0]  es [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
    logic        r  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        dr [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [12:0] ec [10] = '{C_NONE, C_FETCH,
                             13'b0_0_0_0_0_00_00_1_0_0_1, 13'b0_0_0_0_0_00_00_1_0_0_1,
                             13'b0_1_0_0_0_00_00_1_0_0_1, 13'b0_1_0_0_0_00_00_1_0_0_1,
                             13'b0_1_0_0_0_00_00_1_0_0_1, 13'b0_1_0_0_0_00_00_1_0_0_1,
                             13'b0_0_0_1_0_00_00_1_1_0_1, C_NONE};
    instr = 16'hA000; imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); run = r[i]; dmem_ready = dr[i]; #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL ldr cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
    n_checks++;
    if (retired !== 8'd2) $display("FAIL ldr retired: got %0d expected 2", retired);
    else n_pass++;
  endtask

  // SUB sets the stored flags in EXEC; the live flags are driven to the
  // opposite value elsewhere so only the stored copy can steer the branch.
  task automatic test_branch_eq(input logic z, input logic [7:0] exp_ret);
    logic [2:0]  es [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd1, 3'd2, 3'd0};
    logic        r  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ir [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [12:0] ec [9];
    ec = '{C_NONE, C_FETCH,
           13'b0_0_0_0_0_00_01_0_0_0_0, 13'b0_0_0_0_0_00_01_0_0_0_0,
           13'b0_0_0_1_0_00_01_0_1_0_0,
           13'b1_0_0_0_0_00_00_0_0_0_0, C_FETCH,
           {4'b0001, z, 2'b01, 6'b000000}, C_NONE};
    dmem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      run = r[i]; imem_ready = ir[i];
      instr = (i < 5) ? 16'h2000 : 16'hE400;
      alu_flags = (i == 3) ? (z ? 4'b0100 : 4'b0000) : (z ? 4'b0000 : 4'b0100);
      #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL branch_z%0d cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 z, i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
    n_checks++;
    if (retired !== exp_ret)
      $display("FAIL branch_z%0d retired: got %0d expected %0d", z, retired, exp_ret);
    else n_pass++;
  endtask

  task automatic test_str();
    logic [2:0]  es [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic        r  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [12:0] ec [6] = '{C_NONE, C_FETCH,
                            13'b0_0_0_0_0_10_00_1_0_0_0, 13'b0_0_0_0_0_10_00_1_0_0_0,
                            13'b0_1_0_1_0_10_00_1_0_1_0, C_NONE};
    instr = 16'hC000; imem_ready = 1'b1; dmem_ready = 1'b1; alu_flags = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); run = r[i]; #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL str cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
    n_checks++;
    if (retired !== 8'd7) $display("FAIL str retired: got %0d expected 7", retired);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
    logic [12:0] ec [4] = '{C_NONE, C_FETCH, 13'b0_0_0_0_0_01_00_0_0_0_0, C_NONE};
    instr = 16'hFC00; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); run = 1'b1; #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL halt cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = i[0]; imem_ready = i[1]; dmem_ready = i[2];
      #1;
      n_checks++;
      if (state !== 3'd6 || ctl !== C_NONE || retired !== 8'd7)
        $display("FAIL halt hold cyc%0d: state=%0d ctl=%b retired=%0d, expected 6 %b 7",
                 i, state, ctl, retired, C_NONE);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b1; run = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (state !== 3'd0 || retired !== 8'd0 || ctl !== C_NONE)
      $display("FAIL halt rst: state=%0d retired=%0d ctl=%b, expected 0 0 %b",
               state, retired, ctl, C_NONE);
    else n_pass++;
  endtask

  task automatic test_rst_mid_fetch();
    logic [2:0]  es [6] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    logic        r  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        rs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ir [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [12:0] ec [6] = '{C_NONE, 13'b1_0_0_0_0_00_00_0_0_0_0,
                            13'b1_0_0_0_0_00_00_0_0_0_0, C_NONE, C_NONE, C_NONE};
    instr = 16'h0000; dmem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); run = r[i]; rst = rs[i]; imem_ready = ir[i]; #1;
      n_checks++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL rst_fetch cyc%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      else n_pass++;
    end
  endtask

  // 256 back-to-back always-taken branches; every other cycle retires.
  task automatic test_retired_wrap();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; run = 1'b1; imem_ready = 1'b1;
    instr = 16'hE000; alu_flags = 4'h0;
    for (int i = 1; i <= 510; i++) @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (retired !== 8'd255 || state !== 3'd1)
      $display("FAIL wrap pre: retired=%0d state=%0d, expected 255 1", retired, state);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (state !== 3'd2 || pc_write !== 1'b1 || pc_src !== 1'b1)
      $display("FAIL wrap retire: state=%0d pc_write=%b pc_src=%b, expected 2 1 1",
               state, pc_write, pc_src);
    else n_pass++;
    run = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (retired !== 8'd0 || state !== 3'd0)
      $display("FAIL wrap post: retired=%0d state=%0d, expected 0 0", retired, state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_wait();
    test_branch_eq(1'b1, 8'd4);
    test_branch_eq(1'b0, 8'd6);
    test_str();
    test_halt();
    test_rst_mid_fetch();
    test_retired_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
